// File: rtl/button_cmd_sched.sv
// button_cmd_sched: turns debounced button levels into press / hold-to-repeat
// command events and hands them out one at a time over a valid/ready channel,
// arbitrating between buttons round-robin.
module button_cmd_sched #(
  parameter int NB         = 4,
  parameter int ID_W       = 2,
  parameter int CNT_W      = 23,
  parameter int REPEAT_DLY = 6000000,
  parameter int REPEAT_PER = 1200000
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic [NB-1:0]   db_in,
  input  logic [NB-1:0]   rpt_en,
  input  logic            cmd_ready,
  output logic            cmd_valid,
  output logic [ID_W-1:0] cmd_id,
  output logic            cmd_rpt,
  output logic [NB-1:0]   held,
  output logic            overflow
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_t;

  localparam int unsigned     NB_U     = NB;
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  btn_state_t       state_r     [NB];
  btn_state_t       state_nxt_s [NB];
  logic [CNT_W-1:0] timer_r     [NB];
  logic [CNT_W-1:0] timer_nxt_s [NB];

  logic [NB-1:0]   db_prev_r;
  logic [NB-1:0]   rise_s;
  logic [NB-1:0]   fall_s;
  logic [NB-1:0]   post_s;
  logic [NB-1:0]   post_rpt_s;
  logic [NB-1:0]   pending_r;
  logic [NB-1:0]   pend_rpt_r;
  logic [NB-1:0]   pending_nxt_s;
  logic [NB-1:0]   pend_rpt_nxt_s;
  logic [NB-1:0]   held_nxt_s;
  logic [ID_W-1:0] ptr_r;
  logic [ID_W-1:0] grant_idx_s;
  logic            grant_found_s;
  logic            chan_free_s;
  logic            grant_s;
  logic            overflow_nxt_s;

  // Add an offset (< NB) to a button index, wrapping modulo NB.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned    offs);
    int unsigned sum;
    sum = 32'(base) + offs;
    if (sum >= NB_U) begin
      sum = sum - NB_U;
    end else begin
      sum = sum;
    end
    return ID_W'(sum);
  endfunction

  // Edge detect against last cycle's levels.
  always_comb begin
    rise_s = db_in & ~db_prev_r;
    fall_s = ~db_in & db_prev_r;
  end

  // Per-button press/repeat FSM next state; release always wins over timer expiry.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      state_nxt_s[i] = state_r[i];
      timer_nxt_s[i] = timer_r[i];
      post_s[i]      = 1'b0;
      post_rpt_s[i]  = 1'b0;
      if (fall_s[i]) begin
        state_nxt_s[i] = ST_IDLE;
        timer_nxt_s[i] = CNT_ZERO;
      end else begin
        case (state_r[i])
          ST_IDLE: begin
            if (rise_s[i]) begin
              state_nxt_s[i] = ST_WAIT;
              timer_nxt_s[i] = CNT_ZERO;
              post_s[i]      = 1'b1;
            end else begin
              state_nxt_s[i] = ST_IDLE;
            end
          end
          ST_WAIT: begin
            if (timer_r[i] == DLY_LAST) begin
              if (rpt_en[i]) begin
                state_nxt_s[i] = ST_REPEAT;
                timer_nxt_s[i] = CNT_ZERO;
                post_s[i]      = 1'b1;
                post_rpt_s[i]  = 1'b1;
              end else begin
                // Park at the expiry value so enabling repeat later fires at once.
                timer_nxt_s[i] = DLY_LAST;
              end
            end else begin
              timer_nxt_s[i] = timer_r[i] + CNT_ONE;
            end
          end
          ST_REPEAT: begin
            if (timer_r[i] == PER_LAST) begin
              timer_nxt_s[i] = CNT_ZERO;
              post_s[i]      = rpt_en[i];
              post_rpt_s[i]  = rpt_en[i];
            end else begin
              timer_nxt_s[i] = timer_r[i] + CNT_ONE;
            end
          end
          default: begin
            state_nxt_s[i] = ST_IDLE;
            timer_nxt_s[i] = CNT_ZERO;
          end
        endcase
      end
      held_nxt_s[i] = (state_nxt_s[i] != ST_IDLE);
    end
  end

  // Round-robin search: first pending button at or after the pointer.
  always_comb begin
    logic [ID_W-1:0] cand;
    grant_found_s = 1'b0;
    grant_idx_s   = {ID_W{1'b0}};
    cand          = {ID_W{1'b0}};
    for (int unsigned k = 0; k < NB_U; k++) begin
      cand = wrap_add(ptr_r, k);
      if (!grant_found_s && pending_r[cand]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    chan_free_s = ~cmd_valid | cmd_ready;
    grant_s     = chan_free_s & grant_found_s;
  end

  // Pending bookkeeping: new events merge into an un-granted pending one (older flavour kept).
  always_comb begin
    logic gclr;
    pending_nxt_s  = pending_r;
    pend_rpt_nxt_s = pend_rpt_r;
    overflow_nxt_s = 1'b0;
    gclr           = 1'b0;
    for (int i = 0; i < NB; i++) begin
      gclr = grant_s && (grant_idx_s == ID_W'(i));
      if (post_s[i]) begin
        if (pending_r[i] && !gclr) begin
          overflow_nxt_s = 1'b1;
        end else begin
          pending_nxt_s[i]  = 1'b1;
          pend_rpt_nxt_s[i] = post_rpt_s[i];
        end
      end else if (gclr) begin
        pending_nxt_s[i] = 1'b0;
      end else begin
        pending_nxt_s[i] = pending_r[i];
      end
    end
  end

  // Button state, timers, edge history and held flags.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      db_prev_r <= {NB{1'b0}};
      held      <= {NB{1'b0}};
      for (int i = 0; i < NB; i++) begin
        state_r[i] <= ST_IDLE;
        timer_r[i] <= CNT_ZERO;
      end
    end else begin
      db_prev_r <= db_in;
      held      <= held_nxt_s;
      for (int i = 0; i < NB; i++) begin
        state_r[i] <= state_nxt_s[i];
        timer_r[i] <= timer_nxt_s[i];
      end
    end
  end

  // Pending event flags and the overflow pulse.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      pending_r  <= {NB{1'b0}};
      pend_rpt_r <= {NB{1'b0}};
      overflow   <= 1'b0;
    end else begin
      pending_r  <= pending_nxt_s;
      pend_rpt_r <= pend_rpt_nxt_s;
      overflow   <= overflow_nxt_s;
    end
  end

  // Command channel: load on grant, drop valid on an accept with nothing to follow.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cmd_valid <= 1'b0;
      cmd_id    <= {ID_W{1'b0}};
      cmd_rpt   <= 1'b0;
      ptr_r     <= {ID_W{1'b0}};
    end else if (grant_s) begin
      cmd_valid <= 1'b1;
      cmd_id    <= grant_idx_s;
      cmd_rpt   <= pend_rpt_r[grant_idx_s];
      ptr_r     <= wrap_add(grant_idx_s, 32'd1);
    end else if (cmd_valid && cmd_ready) begin
      cmd_valid <= 1'b0;
    end else begin
      cmd_valid <= cmd_valid;
    end
  end

endmodule

// File: tb/tb_button_cmd_sched.sv
// tb_button_cmd_sched: directed scenarios plus random stimulus, checked every
// cycle against a behavioural model of the button command scheduler.
module tb_button_cmd_sched;
  localparam int NB = 4, ID_W = 2, CNT_W = 8, DLY = 20, PER = 8;

  logic            clk = 1'b0;
  logic            n_reset, cmd_ready, cmd_valid, cmd_rpt, overflow;
  logic [NB-1:0]   db_in, rpt_en, held;
  logic [ID_W-1:0] cmd_id;

  button_cmd_sched #(.NB(NB), .ID_W(ID_W), .CNT_W(CNT_W), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
    .clk(clk), .n_reset(n_reset), .db_in(db_in), .rpt_en(rpt_en), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_rpt(cmd_rpt), .held(held), .overflow(overflow));

  always #5 clk = ~clk;

  int n_checks = 0, n_errs = 0, cyc = 0;
  bit chk_en = 1'b0;
  int acc_cyc[$], acc_id[$], acc_rpt[$];
  int ovf_cnt = 0;

  // model state: per-button phase (0 released, 1 waiting, 2 repeating) and age counter
  int  m_mode[NB], m_t[NB], m_ptr, m_id;
  bit  m_pend[NB], m_prpt[NB], m_prev[NB];
  bit  m_valid, m_rpt, m_ovf;
  logic [NB-1:0] m_held;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qget(int q[$], int i);
    if (i < q.size()) return q[i];
    else return -1;
  endfunction

  // One clock of the behavioural model, using the inputs present before the edge.
  task automatic model_step();
    bit rise, fall;
    bit post[NB], prn[NB], oldp[NB];
    int g, idx;
    bit ovf;
    if (n_reset && m_valid && cmd_ready) begin
      acc_cyc.push_back(cyc); acc_id.push_back(m_id); acc_rpt.push_back(int'(m_rpt));
    end
    if (!n_reset) begin
      for (int i = 0; i < NB; i++) begin
        m_mode[i] = 0; m_t[i] = 0; m_pend[i] = 0; m_prpt[i] = 0; m_prev[i] = 0;
      end
      m_ptr = 0; m_valid = 0; m_id = 0; m_rpt = 0; m_ovf = 0; m_held = '0;
      return;
    end
    for (int i = 0; i < NB; i++) begin
      post[i] = 0; prn[i] = 0;
      rise = db_in[i] && !m_prev[i];
      fall = !db_in[i] && m_prev[i];
      if (fall) begin
        m_mode[i] = 0; m_t[i] = 0;
      end else if (m_mode[i] == 0) begin
        if (rise) begin m_mode[i] = 1; m_t[i] = 0; post[i] = 1; end
      end else if (m_mode[i] == 1) begin
        if (m_t[i] == DLY - 1) begin
          if (rpt_en[i]) begin m_mode[i] = 2; m_t[i] = 0; post[i] = 1; prn[i] = 1; end
        end else m_t[i]++;
      end else begin
        if (m_t[i] == PER - 1) begin
          m_t[i] = 0;
          if (rpt_en[i]) begin post[i] = 1; prn[i] = 1; end
        end else m_t[i]++;
      end
      m_prev[i] = db_in[i];
    end
    g = -1;
    if (!m_valid || cmd_ready)
      for (int k = 0; k < NB; k++) begin
        idx = (m_ptr + k) % NB;
        if (g < 0 && m_pend[idx]) g = idx;
      end
    oldp = m_pend;
    if (g >= 0) begin
      m_valid = 1; m_id = g; m_rpt = m_prpt[g]; m_pend[g] = 0; m_ptr = (g + 1) % NB;
    end else if (m_valid && cmd_ready) m_valid = 0;
    ovf = 0;
    for (int i = 0; i < NB; i++)
      if (post[i]) begin
        if (oldp[i] && i != g) ovf = 1;
        else begin m_pend[i] = 1; m_prpt[i] = prn[i]; end
      end
    m_ovf = ovf;
    if (ovf) ovf_cnt++;
    for (int i = 0; i < NB; i++) m_held[i] = (m_mode[i] != 0);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
      #1;
    end
  endtask

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", int'(cmd_valid), int'(m_valid));
      if (m_valid) begin
        check("id", int'(cmd_id), m_id);
        check("rpt", int'(cmd_rpt), int'(m_rpt));
      end
      check("held", int'(held), int'(m_held));
      check("overflow", int'(overflow), int'(m_ovf));
    end
  end

  task automatic clear_log();
    acc_cyc.delete(); acc_id.delete(); acc_rpt.delete(); ovf_cnt = 0;
  endtask

  task automatic do_reset(string tag);
    n_reset = 1'b0;
    tick(2);
    check({tag, "_rst_valid"}, int'(cmd_valid), 0);
    check({tag, "_rst_id"}, int'(cmd_id), 0);
    check({tag, "_rst_rpt"}, int'(cmd_rpt), 0);
    check({tag, "_rst_held"}, int'(held), 0);
    check({tag, "_rst_ovf"}, int'(overflow), 0);
    n_reset = 1'b1;
  endtask

  initial begin
    int r;
    int exp_rel[6];
    n_reset = 1'b0; db_in = '0; rpt_en = '0; cmd_ready = 1'b0;
    exp_rel = '{2, 22, 30, 38, 46, 54};

    // 1: single press
    do_reset("t1");
    chk_en = 1'b1;
    clear_log(); cmd_ready = 1'b1; r = cyc; db_in = 4'b0001;
    tick(10);
    check("t1_count", acc_cyc.size(), 1);
    check("t1_lat", qget(acc_cyc, 0) - r, 2);
    check("t1_id", qget(acc_id, 0), 0);
    check("t1_rpt", qget(acc_rpt, 0), 0);
    check("t1_held", int'(held), 1);

    // 2: hold-to-repeat on button 2
    db_in = '0; tick(2);
    clear_log(); rpt_en = 4'b0100; r = cyc; db_in = 4'b0100;
    tick(60);
    check("t2_count", acc_cyc.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_rel%0d", i), qget(acc_cyc, i) - r, exp_rel[i]);
      check($sformatf("t2_id%0d", i), qget(acc_id, i), 2);
      check($sformatf("t2_rpt%0d", i), qget(acc_rpt, i), (i == 0) ? 0 : 1);
    end
    check("t2_held_on", int'(held), 4'b0100);
    db_in = '0; tick(12);
    check("t2_after_release", acc_cyc.size(), 6);
    check("t2_held_off", int'(held), 0);

    // 3: simultaneous presses, round-robin order
    rpt_en = '0;
    do_reset("t3");
    for (int pass = 0; pass < 2; pass++) begin
      clear_log(); cmd_ready = 1'b1; r = cyc; db_in = 4'b1011;
      tick(8);
      check("t3_count", acc_cyc.size(), 3);
      check("t3_id0", qget(acc_id, 0), 0);
      check("t3_id1", qget(acc_id, 1), 1);
      check("t3_id2", qget(acc_id, 2), 3);
      check("t3_rel0", qget(acc_cyc, 0) - r, 2);
      check("t3_rel2", qget(acc_cyc, 2) - r, 4);
      db_in = '0; tick(2);
    end

    // 4: overflow while the channel is stalled
    do_reset("t4");
    clear_log(); cmd_ready = 1'b0; db_in = 4'b0001;
    tick(4);
    db_in = 4'b0011; tick(1);
    db_in = 4'b0001; tick(1);
    db_in = 4'b0011; tick(3);
    check("t4_ovf_count", ovf_cnt, 1);
    cmd_ready = 1'b1; tick(6);
    check("t4_count", acc_cyc.size(), 2);
    check("t4_id0", qget(acc_id, 0), 0);
    check("t4_id1", qget(acc_id, 1), 1);
    check("t4_rpt1", qget(acc_rpt, 1), 0);

    // 5: repeat disabled, then enabled mid-hold
    db_in = '0;
    do_reset("t5");
    clear_log(); cmd_ready = 1'b1; rpt_en = '0; r = cyc; db_in = 4'b0001;
    tick(3 * DLY);
    check("t5_count", acc_cyc.size(), 1);
    check("t5_rpt", qget(acc_rpt, 0), 0);
    clear_log(); r = cyc; rpt_en = 4'b0001;
    tick(4);
    check("t5_en_count", acc_cyc.size(), 1);
    check("t5_en_rel", qget(acc_cyc, 0) - r, 2);
    check("t5_en_rpt", qget(acc_rpt, 0), 1);
    db_in = '0; rpt_en = '0; tick(2);

    // 6: reset during a stalled command with a button in repeat
    do_reset("t6");
    cmd_ready = 1'b0; rpt_en = 4'b0001; db_in = 4'b0001;
    tick(25);
    check("t6_valid_before", int'(cmd_valid), 1);
    n_reset = 1'b0; tick(1);
    check("t6_valid", int'(cmd_valid), 0);
    check("t6_held", int'(held), 0);
    check("t6_id", int'(cmd_id), 0);
    check("t6_rpt", int'(cmd_rpt), 0);
    check("t6_ovf", int'(overflow), 0);
    clear_log(); cmd_ready = 1'b1; r = cyc; n_reset = 1'b1;
    tick(5);
    check("t6_count", acc_cyc.size(), 1);
    check("t6_rel", qget(acc_cyc, 0) - r, 2);
    check("t6_fresh_rpt", qget(acc_rpt, 0), 0);
    check("t6_fresh_id", qget(acc_id, 0), 0);

    // random phase
    db_in = '0; rpt_en = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 39) == 0) db_in[i] = ~db_in[i];
        if ($urandom_range(0, 63) == 0) rpt_en[i] = ~rpt_en[i];
      end
      cmd_ready = ($urandom_range(0, 3) != 0);
      n_reset = ($urandom_range(0, 499) != 0);
      tick(1);
    end
    n_reset = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
